// File: rtl/turbo_iter_ctrl_pkg.sv
// Shared definitions for the turbo decoder iteration controller: state encoding,
// default sizes and the 7-entry interleaver permutation.
package turbo_iter_ctrl_pkg;

    localparam int EXTEND_SIZE_DEF = 7;
    localparam int MAX_ITER_DEF    = 8;
    localparam int ADDR_W          = 3;
    localparam int ITER_W          = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT,
        WRITE,
        CHECK,
        DONE
    } state_t;

    // Interleaver order used for the second (interleaved) half-iteration.
    function automatic logic [ADDR_W-1:0] perm(input logic [ADDR_W-1:0] idx);
        logic [ADDR_W-1:0] result;
        case (idx)
            3'd0:    result = 3'd3;
            3'd1:    result = 3'd0;
            3'd2:    result = 3'd5;
            3'd3:    result = 3'd1;
            3'd4:    result = 3'd6;
            3'd5:    result = 3'd2;
            3'd6:    result = 3'd4;
            default: result = idx;
        endcase
        return result;
    endfunction

    // Zero requests still run one iteration; requests above the cap are clamped.
    function automatic logic [ITER_W-1:0] eff_iter(input logic [ITER_W-1:0] req,
                                                   input int max_iter);
        logic [ITER_W-1:0] result;
        if (req == '0)
            result = ITER_W'(1);
        else if (int'(req) > max_iter)
            result = ITER_W'(max_iter);
        else
            result = req;
        return result;
    endfunction

endpackage

// File: rtl/turbo_iter_ctrl_timer.sv
// WAIT-state watchdog: counts cycles while enabled and flags the last allowed cycle.
module turbo_iter_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && !expired) begin
            count_reg <= count_reg + TW'(1);
        end
    end

    assign expired = (count_reg == TW'(TIMEOUT - 1));

endmodule

// File: rtl/turbo_iter_ctrl.sv
// Turbo decoder iteration controller: sequences SISO loads, waits for results,
// writes extrinsics and counts half/full iterations until the requested count.
module turbo_iter_ctrl
    import turbo_iter_ctrl_pkg::*;
#(
    parameter int EXTEND_SIZE = EXTEND_SIZE_DEF,
    parameter int MAX_ITER    = MAX_ITER_DEF,
    parameter int TIMEOUT     = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ITER_W-1:0] num_iter_i,
    input  logic              abort_i,
    input  logic              siso_done_i,
    output logic              siso_read_en_o,
    output logic [ADDR_W-1:0] siso_addr_o,
    output logic              half_o,
    output logic              ext_wr_en_o,
    output logic [ITER_W-1:0] iter_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [ADDR_W-1:0] LOAD_LAST = ADDR_W'(EXTEND_SIZE - 1);

    state_t            state_reg,    state_next;
    logic [ADDR_W-1:0] load_cnt_reg, load_cnt_next;
    logic              half_reg,     half_next;
    logic [ITER_W-1:0] iter_reg,     iter_next;
    logic [ITER_W-1:0] n_iter_reg,   n_iter_next;
    logic              err_reg,      err_next;

    logic              timer_expired;
    logic [ITER_W-1:0] iter_inc;

    turbo_iter_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk_i),
        .rst     (rst_i),
        .clear   (state_reg != WAIT),
        .enable  (state_reg == WAIT),
        .expired (timer_expired)
    );

    assign iter_inc = (iter_reg == '1) ? iter_reg : iter_reg + ITER_W'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            load_cnt_reg <= '0;
            half_reg     <= 1'b0;
            iter_reg     <= '0;
            n_iter_reg   <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            load_cnt_reg <= load_cnt_next;
            half_reg     <= half_next;
            iter_reg     <= iter_next;
            n_iter_reg   <= n_iter_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        load_cnt_next = load_cnt_reg;
        half_next     = half_reg;
        iter_next     = iter_reg;
        n_iter_next   = n_iter_reg;
        err_next      = err_reg;

        unique case (state_reg)
            IDLE: begin
                if (start_i) begin
                    n_iter_next   = eff_iter(num_iter_i, MAX_ITER);
                    iter_next     = '0;
                    half_next     = 1'b0;
                    err_next      = 1'b0;
                    load_cnt_next = '0;
                    state_next    = LOAD;
                end
            end
            LOAD: begin
                if (load_cnt_reg == LOAD_LAST) begin
                    load_cnt_next = '0;
                    state_next    = WAIT;
                end else begin
                    load_cnt_next = load_cnt_reg + ADDR_W'(1);
                end
            end
            WAIT: begin
                // A result arriving on the final allowed cycle still counts.
                if (siso_done_i) begin
                    state_next = WRITE;
                end else if (timer_expired) begin
                    err_next   = 1'b1;
                    state_next = DONE;
                end
            end
            WRITE: begin
                state_next = CHECK;
            end
            CHECK: begin
                if (!half_reg) begin
                    half_next  = 1'b1;
                    state_next = LOAD;
                end else begin
                    half_next  = 1'b0;
                    iter_next  = iter_inc;
                    state_next = (iter_inc == n_iter_reg) ? DONE : LOAD;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Abort wins over everything except an already-pending DONE, which
        // must stay a single-cycle pulse.
        if (abort_i && state_reg != IDLE && state_reg != DONE) begin
            state_next    = DONE;
            load_cnt_next = '0;
            half_next     = half_reg;
            iter_next     = iter_reg;
            err_next      = err_reg;
        end
    end

    assign siso_read_en_o = (state_reg == LOAD);
    assign siso_addr_o    = (state_reg != LOAD) ? '0 :
                            (half_reg ? perm(load_cnt_reg) : load_cnt_reg);
    assign half_o         = half_reg;
    assign ext_wr_en_o    = (state_reg == WRITE);
    assign iter_o         = iter_reg;
    assign busy_o         = (state_reg != IDLE);
    assign done_o         = (state_reg == DONE);
    assign err_o          = err_reg;

endmodule

// File: tb/tb_turbo_iter_ctrl.sv
// Randomized bench for turbo_iter_ctrl with a decode-level reference model
// (burst counts, address orders, latency formula, timeout/abort outcomes).
module tb_turbo_iter_ctrl;

    localparam int ES = 7;
    localparam int MI = 8;
    localparam int TO = 64;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic [3:0] num_iter_i;
    logic       abort_i;
    logic       siso_done_i;
    logic       siso_read_en_o;
    logic [2:0] siso_addr_o;
    logic       half_o;
    logic       ext_wr_en_o;
    logic [3:0] iter_o;
    logic       busy_o;
    logic       done_o;
    logic       err_o;

    int n_checks = 0;
    int n_fail   = 0;
    int perm_ref [ES] = '{3, 0, 5, 1, 6, 2, 4};

    always #5 clk_i = ~clk_i;

    turbo_iter_ctrl #(
        .EXTEND_SIZE (ES),
        .MAX_ITER    (MI),
        .TIMEOUT     (TO)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .num_iter_i     (num_iter_i),
        .abort_i        (abort_i),
        .siso_done_i    (siso_done_i),
        .siso_read_en_o (siso_read_en_o),
        .siso_addr_o    (siso_addr_o),
        .half_o         (half_o),
        .ext_wr_en_o    (ext_wr_en_o),
        .iter_o         (iter_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .err_o          (err_o)
    );

    task automatic check_eq(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic int outputs_word();
        return int'({siso_read_en_o, siso_addr_o, half_o, ext_wr_en_o,
                     iter_o, busy_o, done_o, err_o});
    endfunction

    // One decode. w = WAIT cycles per half including the siso_done cycle.
    // to_half >= 0 withholds siso_done in that half; ab_burst >= 0 aborts on
    // load cycle ab_k of that burst while also pulsing start.
    task automatic run_decode(input int num, input int w, input int to_half,
                              input int ab_burst, input int ab_k,
                              input bit stray, input bit start_abort);
        int n_eff, p, halves, exp_done_c, exp_bursts, exp_iter, exp_err, exp_len;
        int c, bursts, blen, writes, dones, done_c, wcnt;
        bit in_wait, prev_rd, finished;

        n_eff = (num == 0) ? 1 : (num > MI) ? MI : num;
        p     = ES + w + 2;
        if (ab_burst >= 0) begin
            halves     = ab_burst;
            exp_bursts = ab_burst + 1;
            exp_err    = 0;
            exp_done_c = 1 + ab_burst * p + ab_k;
        end else if (to_half >= 0) begin
            halves     = to_half;
            exp_bursts = to_half + 1;
            exp_err    = 1;
            exp_done_c = 1 + to_half * p + ES + TO;
        end else begin
            halves     = 2 * n_eff;
            exp_bursts = 2 * n_eff;
            exp_err    = 0;
            exp_done_c = 1 + n_eff * 2 * (ES + w + 2);
        end
        exp_iter = halves / 2;

        start_i    = 1'b1;
        num_iter_i = 4'(num);
        abort_i    = start_abort;
        step();
        start_i = 1'b0;
        abort_i = 1'b0;

        check_eq("busy_after_start", busy_o, 1);
        check_eq("iter_cleared", iter_o, 0);
        check_eq("err_cleared", err_o, 0);

        c = 1; bursts = 0; blen = 0; writes = 0; dones = 0; done_c = 0; wcnt = 0;
        in_wait = 0; prev_rd = 0; finished = 0;
        while (!finished && c < 3000) begin
            siso_done_i = 1'b0;
            if (siso_read_en_o) begin
                if (!prev_rd) begin
                    bursts++;
                    blen = 0;
                end
                check_eq("half_sel", half_o, (bursts - 1) % 2);
                check_eq("addr", siso_addr_o,
                         (blen >= ES) ? -1 : (((bursts - 1) % 2) ? perm_ref[blen] : blen));
                blen++;
                if (stray && blen == 2)
                    siso_done_i = 1'b1;
                if (ab_burst == bursts - 1 && blen == ab_k) begin
                    abort_i = 1'b1;
                    start_i = 1'b1;
                end
            end else begin
                if (prev_rd) begin
                    exp_len = (ab_burst == bursts - 1) ? ab_k : ES;
                    check_eq("burst_len", blen, exp_len);
                    in_wait = 1;
                    wcnt    = 0;
                end
                if (in_wait && !done_o) begin
                    wcnt++;
                    if (bursts - 1 != to_half && wcnt == w) begin
                        siso_done_i = 1'b1;
                        in_wait     = 0;
                    end
                end
            end
            if (ext_wr_en_o)
                writes++;
            if (done_o) begin
                dones++;
                done_c   = c;
                finished = 1;
            end
            prev_rd = siso_read_en_o;
            step();
            c++;
            abort_i     = 1'b0;
            start_i     = 1'b0;
            siso_done_i = 1'b0;
        end

        check_eq("done_seen", finished, 1);
        check_eq("latency", done_c + 1, exp_done_c + 1);
        check_eq("read_bursts", bursts, exp_bursts);
        check_eq("ext_writes", writes, halves);
        check_eq("done_pulses", dones, 1);
        check_eq("done_one_cycle", done_o, 0);
        check_eq("busy_after_done", busy_o, 0);
        check_eq("iter_final", iter_o, exp_iter);
        check_eq("err_final", err_o, exp_err);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("idle_stays_idle", busy_o, 0);
        end
        check_eq("iter_hold", iter_o, exp_iter);
        $display("decode num=%0d w=%0d to_half=%0d abort=%0d/%0d lat=%0d iter=%0d err=%0d",
                 num, w, to_half, ab_burst, ab_k, done_c + 1, iter_o, err_o);
    endtask

    initial begin
        int falls, guard;
        bit prev;

        rst_i       = 1'b1;
        start_i     = 1'b0;
        num_iter_i  = 4'd0;
        abort_i     = 1'b0;
        siso_done_i = 1'b0;
        step();
        step();
        check_eq("reset_outputs", outputs_word(), 0);
        rst_i = 1'b0;
        step();
        check_eq("idle_after_reset", busy_o, 0);

        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        check_eq("abort_in_idle", busy_o, 0);

        run_decode(2, 3, -1, -1, 1, 1'b0, 1'b0);
        run_decode(0, 2, -1, -1, 1, 1'b1, 1'b0);
        run_decode(15, 1, -1, -1, 1, 1'b0, 1'b0);
        run_decode(2, 2, 1, -1, 1, 1'b0, 1'b0);
        run_decode(3, 4, -1, 2, 4, 1'b0, 1'b0);
        run_decode(1, 5, -1, -1, 1, 1'b1, 1'b1);

        for (int t = 0; t < 8; t++) begin
            int num, w, mode, ne, th, ab, k;
            num  = int'($urandom_range(0, 15));
            w    = int'($urandom_range(1, 12));
            mode = int'($urandom_range(0, 2));
            ne   = (num == 0) ? 1 : (num > MI) ? MI : num;
            th   = -1;
            ab   = -1;
            k    = 1;
            if (mode == 1) begin
                th = int'($urandom_range(0, 2 * ne - 1));
            end else if (mode == 2) begin
                ab = int'($urandom_range(0, 2 * ne - 1));
                k  = int'($urandom_range(1, ES));
            end
            run_decode(num, w, th, ab, k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset during the WAIT of the second half of iteration 2.
        start_i    = 1'b1;
        num_iter_i = 4'd2;
        step();
        start_i = 1'b0;
        falls   = 0;
        guard   = 0;
        prev    = 1'b0;
        while (falls < 4 && guard < 500) begin
            siso_done_i = 1'b0;
            if (prev && !siso_read_en_o) begin
                falls++;
                if (falls < 4)
                    siso_done_i = 1'b1;
            end
            prev = siso_read_en_o;
            step();
            guard++;
        end
        siso_done_i = 1'b0;
        check_eq("pre_reset_busy", busy_o, 1);
        check_eq("pre_reset_half", half_o, 1);
        check_eq("pre_reset_iter", iter_o, 1);
        #2 rst_i = 1'b1;
        #1;
        check_eq("async_reset_outputs", outputs_word(), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("no_done_in_reset", done_o, 0);
        end
        rst_i = 1'b0;
        step();
        check_eq("idle_after_mid_reset", outputs_word(), 0);
        $display("reset mid-decode: outputs cleared");
        run_decode(2, 3, -1, -1, 1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
